wave_voice_sequencer: RTL and testbench

Time-multiplexes one combinational wave lookup table (6-bit ramp in, 16-bit signed sample out) among several tone voices. Each voice has a 16-bit phase accumulator and a programmable increment. On every sample-rate tick the block steps through the voices, reads the shared table once per voice, and mixes the results. The mixed sample goes to the audio DAC path. It sits between the CPU-side sound registers and the wave table.

---
 rtl/wave_voice_sequencer_if.sv | 34 +++
 rtl/wave_voice_sequencer.sv | 177 +++++++++++++++++
 tb/tb_wave_voice_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_voice_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : wave_voice_sequencer_if
// Brief    : Bus bundle for wave_voice_sequencer: sample strobe, CPU register
//            write port, shared wave-table lookup and mixed-sample outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface wave_voice_sequencer_if;
  logic        sample_tick;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  ramp_o;
  logic [15:0] music_i;
  logic [15:0] mix_o;
  logic        mix_valid;
  logic        busy;
  logic        overrun;

  // Environment side: CPU registers, tick source, wave table, DAC path
  modport master (
    output sample_tick, wr_en, wr_addr, wr_data, music_i,
    input  ramp_o, mix_o, mix_valid, busy, overrun
  );

  // Sequencer side
  modport slave (
    input  sample_tick, wr_en, wr_addr, wr_data, music_i,
    output ramp_o, mix_o, mix_valid, busy, overrun
  );
endinterface

`default_nettype wire

// File: rtl/wave_voice_sequencer.sv
//------------------------------------------------------------------------------
// Module   : wave_voice_sequencer
// Brief    : Time-multiplexes one combinational wave table among 2^VOICE_BITS
//            tone voices, one voice per cycle after each sample tick, and
//            mixes the samples into a registered output.
//            Optional feature macro: WAVE_MIX_SAT_EN
//              defined   -> full-scale sum saturated to 16 bits
//              undefined -> sum arithmetically shifted by VOICE_BITS (average)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wave_voice_sequencer #(
  parameter int VOICE_BITS = 2
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  wave_voice_sequencer_if.slave         bus
);

  localparam int NUM_VOICES = 1 << VOICE_BITS;
  localparam int ACC_W      = 16 + VOICE_BITS;
  localparam int VIDX_W     = (VOICE_BITS == 0) ? 1 : VOICE_BITS;

  localparam logic [2:0]        c_NUM_V = 3'(NUM_VOICES);
  localparam logic [VIDX_W-1:0] c_LAST  = VIDX_W'(NUM_VOICES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [VIDX_W-1:0]       vidx_q, vidx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]             mix_q, mix_d;
  logic                    mix_valid_q, mix_valid_d;
  logic                    overrun_q;

  logic [15:0]             inc_q   [NUM_VOICES];
  logic [15:0]             phase_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]   en_q;

  logic                    w_wr_inc;
  logic                    w_wr_ctl;
  logic                    w_phase_clr;
  logic signed [15:0]      w_music;
  logic signed [ACC_W-1:0] w_contrib;
  logic signed [ACC_W-1:0] w_sum;
  logic [15:0]             w_scaled;
  logic                    w_unused_ok;

  assign w_wr_inc    = bus.wr_en && (bus.wr_addr < c_NUM_V);
  assign w_wr_ctl    = bus.wr_en && (bus.wr_addr == 3'd7);
  assign w_phase_clr = w_wr_ctl && bus.wr_data[9];

  // The table answers in the same cycle, so the current voice's sample is
  // folded straight into the running sum.
  assign w_music   = bus.music_i;
  assign w_contrib = en_q[vidx_q] ? ACC_W'(w_music) : '0;
  assign w_sum     = acc_q + w_contrib;

`ifdef WAVE_MIX_SAT_EN
  localparam logic signed [ACC_W-1:0] c_SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] c_SAT_MIN = ACC_W'(-32768);

  // Clamp the full-scale sum into the 16-bit signed range
  always_comb begin
    w_scaled = w_sum[15:0];
    if (w_sum > c_SAT_MAX) begin
      w_scaled = 16'h7FFF;
    end else if (w_sum < c_SAT_MIN) begin
      w_scaled = 16'h8000;
    end
  end

  assign w_unused_ok = ^bus.wr_data;
`else
  logic signed [ACC_W-1:0] w_shift;

  // Average of the voices; the shifted sum always fits 16 bits
  assign w_shift     = w_sum >>> VOICE_BITS;
  assign w_scaled    = w_shift[15:0];
  assign w_unused_ok = ^{bus.wr_data, w_shift};
`endif

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      vidx_q      <= '0;
      acc_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vidx_q      <= vidx_d;
      acc_q       <= acc_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
    end
  end

  // Next-state: wait for a tick, then walk the voices and publish the mix
  always_comb begin
    state_d     = state_q;
    vidx_d      = vidx_q;
    acc_d       = acc_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        vidx_d = '0;
        acc_d  = '0;
        if (bus.sample_tick) begin
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = w_sum;
        if (vidx_q == c_LAST) begin
          state_d     = IDLE;
          vidx_d      = '0;
          acc_d       = '0;
          mix_d       = w_scaled;
          mix_valid_d = 1'b1;
        end else begin
          vidx_d = vidx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // CPU-visible voice registers and phase accumulators; a phase clear
  // overrides the RUN-cycle advance, and a tick in RUN beats an overrun clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        inc_q[v]   <= '0;
        phase_q[v] <= '0;
      end
      en_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (w_wr_inc) begin
        inc_q[bus.wr_addr[VIDX_W-1:0]] <= bus.wr_data;
      end
      if (w_wr_ctl) begin
        en_q <= bus.wr_data[NUM_VOICES-1:0];
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (w_phase_clr) begin
          phase_q[v] <= '0;
        end else if ((state_q == RUN) && (vidx_q == VIDX_W'(v)) && en_q[v]) begin
          phase_q[v] <= phase_q[v] + inc_q[v];
        end
      end
      if ((state_q == RUN) && bus.sample_tick) begin
        overrun_q <= 1'b1;
      end else if (w_wr_ctl && bus.wr_data[8]) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.ramp_o    = phase_q[vidx_q][15:10];
  assign bus.mix_o     = mix_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_wave_voice_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_wave_voice_sequencer
// Brief    : Directed self-checking bench for wave_voice_sequencer with four
//            voices and a wave-table stub (square / +max / -max).
//            Expected mixes follow WAVE_MIX_SAT_EN when it is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wave_voice_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;
  logic [5:0] ramps [4];

`ifdef WAVE_MIX_SAT_EN
  localparam logic [15:0] E_SQ1_LO = 16'hE000;
  localparam logic [15:0] E_SQ1_HI = 16'h1FFF;
  localparam logic [15:0] E_SQ4_LO = 16'h8000;
  localparam logic [15:0] E_SQ4_HI = 16'h7FFC;
  localparam logic [15:0] E_DIS    = 16'hC000;
`else
  localparam logic [15:0] E_SQ1_LO = 16'hF800;
  localparam logic [15:0] E_SQ1_HI = 16'h07FF;
  localparam logic [15:0] E_SQ4_LO = 16'hE000;
  localparam logic [15:0] E_SQ4_HI = 16'h1FFF;
  localparam logic [15:0] E_DIS    = 16'hF000;
`endif

  always #5 clk = ~clk;

  wave_voice_sequencer_if bus();

  wave_voice_sequencer #(.VOICE_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Wave table stub
  assign bus.music_i = (mode == 1) ? 16'h7FFF :
                       (mode == 2) ? 16'h8000 :
                       (bus.ramp_o < 6'd32) ? 16'hE000 : 16'h1FFF;

  task automatic wr(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Issue one tick, record the ramp seen in each RUN cycle, return the mix
  task automatic do_frame(output logic [15:0] mix);
    int lat;
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    lat = 1;
    ramps[0] = bus.ramp_o;
    while (!bus.mix_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat <= 4) ramps[lat-1] = bus.ramp_o;
    end
    mix = bus.mix_o;
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL frame_latency: got %0d cycles, want 5", lat);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mix_o, bus.ramp_o, bus.busy, bus.overrun, bus.mix_valid} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: mix=%h ramp=%h busy=%b ovr=%b valid=%b, want all 0",
               bus.mix_o, bus.ramp_o, bus.busy, bus.overrun, bus.mix_valid);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.mix_o, bus.ramp_o, bus.busy, bus.mix_valid} !== 24'd0) begin
        errors++;
        $display("FAIL idle_static: mix=%h ramp=%h busy=%b valid=%b, want all 0",
                 bus.mix_o, bus.ramp_o, bus.busy, bus.mix_valid);
      end
    end
  endtask

  task automatic test_single_voice;
    logic [15:0] mix;
    logic [15:0] exp;
    wr(3'd0, 16'h0400);
    wr(3'd7, 16'h0201);
    for (int k = 0; k <= 32; k++) begin
      do_frame(mix);
      exp = (k < 32) ? E_SQ1_LO : E_SQ1_HI;
      checks++;
      if (mix !== exp || ramps[0] !== 6'(k)) begin
        errors++;
        $display("FAIL single_voice frame %0d: mix=%h ramp=%0d, want mix=%h ramp=%0d",
                 k, mix, ramps[0], exp, k);
      end
    end
  endtask

  task automatic test_four_voice;
    logic [15:0] mix;
    for (int v = 0; v < 4; v++) wr(3'(v), 16'h8000);
    wr(3'd7, 16'h020F);
    do_frame(mix);
    checks++;
    if (mix !== E_SQ4_LO) begin
      errors++;
      $display("FAIL four_voice_f0: got %h, want %h", mix, E_SQ4_LO);
    end
    do_frame(mix);
    checks++;
    if (mix !== E_SQ4_HI) begin
      errors++;
      $display("FAIL four_voice_f1: got %h, want %h", mix, E_SQ4_HI);
    end
  endtask

  task automatic test_saturation;
    logic [15:0] mix;
    mode = 1;
    do_frame(mix);
    checks++;
    if (mix !== 16'h7FFF) begin
      errors++;
      $display("FAIL sat_pos: got %h, want 7fff", mix);
    end
    mode = 2;
    do_frame(mix);
    checks++;
    if (mix !== 16'h8000) begin
      errors++;
      $display("FAIL sat_neg: got %h, want 8000", mix);
    end
    mode = 0;
  endtask

  task automatic test_overrun;
    int nvalid = 0;
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (bus.mix_valid) nvalid++;
      if (i == 2) bus.sample_tick = 1'b1;
      if (i == 3) bus.sample_tick = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (nvalid != 1) begin
      errors++;
      $display("FAIL overrun_single_valid: got %0d pulses, want 1", nvalid);
    end
    checks++;
    if (bus.overrun !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_flag: ovr=%b busy=%b, want ovr=1 busy=0", bus.overrun, bus.busy);
    end
    wr(3'd7, 16'h010F);
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b, want 0", bus.overrun);
    end
  endtask

  task automatic test_reset_midframe;
    int nvalid = 0;
    // Two-cycle tick: second sample lands in RUN and raises overrun
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.sample_tick = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mix_o, bus.ramp_o, bus.busy, bus.overrun, bus.mix_valid} !== 25'd0) begin
      errors++;
      $display("FAIL midframe_reset: mix=%h ramp=%h busy=%b ovr=%b valid=%b, want all 0",
               bus.mix_o, bus.ramp_o, bus.busy, bus.overrun, bus.mix_valid);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mix_valid) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL aborted_frame_valid: got %0d pulses, want 0", nvalid);
    end
  endtask

  task automatic test_disabled_voice;
    logic [15:0] mix;
    wr(3'd0, 16'h0400);
    wr(3'd1, 16'h1234);
    wr(3'd2, 16'h0800);
    wr(3'd7, 16'h0205);
    for (int k = 0; k < 10; k++) begin
      do_frame(mix);
      checks++;
      if (mix !== E_DIS || ramps[0] !== 6'(k) || ramps[1] !== 6'd0 || ramps[2] !== 6'(2*k)) begin
        errors++;
        $display("FAIL disabled_voice frame %0d: mix=%h r0=%0d r1=%0d r2=%0d, want mix=%h r0=%0d r1=0 r2=%0d",
                 k, mix, ramps[0], ramps[1], ramps[2], E_DIS, k, 2*k);
      end
    end
  endtask

  initial begin
    bus.sample_tick = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = 3'd0;
    bus.wr_data     = 16'h0000;
    test_reset();
    test_single_voice();
    test_four_voice();
    test_saturation();
    test_overrun();
    test_reset_midframe();
    test_disabled_voice();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
